// File: rtl/maze_pkg.sv
// maze_pkg: shared definitions for the maze display path.
//   - default maze dimensions and the bitmap cell encoding
//   - RRRGGGBB colour constants
//   - 640x480@60 VGA timing constants (counter positions, sync ends inclusive)
//   - vga_decode_t: per-position decode bundle passed from the timing
//     generator to the renderer
//   - in_span(): inclusive range test on counter values
package maze_pkg;

    localparam int MAZE_W_DEF = 16;
    localparam int MAZE_H_DEF = 16;

    // Width of the h/v pixel counters; all window arithmetic uses this width.
    localparam int CNT_W = 10;
    localparam logic [CNT_W-1:0] CNT_ONE = 10'd1;

    // Bitmap cell encoding.
    localparam logic CELL_PATH = 1'b1;
    localparam logic CELL_WALL = 1'b0;

    // Colours, RRRGGGBB.
    localparam logic [7:0] COL_BLANK  = 8'h00;
    localparam logic [7:0] COL_BORDER = 8'h03;
    localparam logic [7:0] COL_PATH   = 8'hFF;
    localparam logic [7:0] COL_WALL   = 8'h00;
    localparam logic [7:0] COL_CURSOR = 8'hE0;
    localparam logic [7:0] COL_GRID   = 8'h92;

    // VGA 640x480@60 timing, in pixel ticks / lines.
    localparam int H_ACTIVE     = 640;
    localparam int H_SYNC_START = 656;
    localparam int H_SYNC_END   = 751;
    localparam int H_TOTAL      = 800;
    localparam int V_ACTIVE     = 480;
    localparam int V_SYNC_START = 490;
    localparam int V_SYNC_END   = 491;
    localparam int V_TOTAL      = 525;

    // Combinational decode of the current counter position.
    typedef struct packed {
        logic hsync;        // active low
        logic vsync;        // active low
        logic active;       // inside the visible area
        logic frame_start;  // position (0,0)
        logic snap;         // position (0,V_ACTIVE): snapshot point
    } vga_decode_t;

    // Inclusive range test on counter values.
    function automatic logic in_span(input logic [CNT_W-1:0] val,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: horizontal/vertical pixel counters and position decode.
// Counters advance only on pix_en; decode is combinational on the counters,
// the consumer registers it.
// Ports:
//   clk, reset (sync, active high), pix_en (pixel-rate enable)
//   h_cnt, v_cnt : current counter position
//   decode       : raw sync, active area, frame start and snapshot point
module vga_timing_gen
    import maze_pkg::*;
#(
    parameter int H_ACTIVE_CFG     = H_ACTIVE,
    parameter int H_SYNC_START_CFG = H_SYNC_START,
    parameter int H_SYNC_END_CFG   = H_SYNC_END,
    parameter int H_TOTAL_CFG      = H_TOTAL,
    parameter int V_ACTIVE_CFG     = V_ACTIVE,
    parameter int V_SYNC_START_CFG = V_SYNC_START,
    parameter int V_SYNC_END_CFG   = V_SYNC_END,
    parameter int V_TOTAL_CFG      = V_TOTAL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_en,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output vga_decode_t      decode
);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL_CFG - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL_CFG - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE_CFG);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE_CFG);
    localparam logic [CNT_W-1:0] H_SS     = CNT_W'(H_SYNC_START_CFG);
    localparam logic [CNT_W-1:0] H_SE     = CNT_W'(H_SYNC_END_CFG);
    localparam logic [CNT_W-1:0] V_SS     = CNT_W'(V_SYNC_START_CFG);
    localparam logic [CNT_W-1:0] V_SE     = CNT_W'(V_SYNC_END_CFG);
    localparam logic [CNT_W-1:0] CNT_ZERO = 10'd0;

    logic [CNT_W-1:0] h_cnt_r;
    logic [CNT_W-1:0] v_cnt_r;
    vga_decode_t      decode_s;

    // Pixel/line counters: h wraps at end of line and carries into v.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_r <= CNT_ZERO;
            v_cnt_r <= CNT_ZERO;
        end else if (pix_en) begin
            if (h_cnt_r == H_LAST) begin
                h_cnt_r <= CNT_ZERO;
                if (v_cnt_r == V_LAST) begin
                    v_cnt_r <= CNT_ZERO;
                end else begin
                    v_cnt_r <= v_cnt_r + CNT_ONE;
                end
            end else begin
                h_cnt_r <= h_cnt_r + CNT_ONE;
            end
        end
    end

    // Position decode for the renderer's output registers.
    always_comb begin
        decode_s             = '{default: 1'b0};
        decode_s.hsync       = ~in_span(h_cnt_r, H_SS, H_SE);
        decode_s.vsync       = ~in_span(v_cnt_r, V_SS, V_SE);
        decode_s.active      = (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
        decode_s.frame_start = (h_cnt_r == CNT_ZERO) && (v_cnt_r == CNT_ZERO);
        decode_s.snap        = (h_cnt_r == CNT_ZERO) && (v_cnt_r == V_ACT);
    end

    assign h_cnt  = h_cnt_r;
    assign v_cnt  = v_cnt_r;
    assign decode = decode_s;

endmodule

// File: rtl/maze_vga_renderer.sv
// maze_vga_renderer: draws the carver's maze bitmap and a player cursor on a
// 640x480@60 VGA raster. Maze, cursor and finish flag are snapshotted once per
// frame at the start of vertical blanking so updates never tear the picture.
// Optional build macro: MAZE_GRID_LINES_EN draws grid lines on the first
// pixel row/column of each cell (cursor still drawn on top).
// Ports:
//   clk, reset (sync, active high), pix_en (25 MHz pixel enable)
//   maze_data[MAZE_W*MAZE_H] (bit x+MAZE_W*y, 1 = path), maze_finish,
//   cursor_x/cursor_y (cell coordinates)
//   hsync, vsync (active low), video_on, rgb (RRRGGGBB), frame_start (one clk
//   at pixel (0,0)), snapshot_valid (snapshot taken with maze_finish = 1)
// All outputs are registered and lag the counters by one pixel tick.
module maze_vga_renderer
    import maze_pkg::*;
#(
    parameter int MAZE_W           = MAZE_W_DEF,
    parameter int MAZE_H           = MAZE_H_DEF,
    parameter int CELL_PX          = 16,
    parameter int ORIGIN_X         = 192,
    parameter int ORIGIN_Y         = 112,
    parameter int H_ACTIVE_CFG     = H_ACTIVE,
    parameter int H_SYNC_START_CFG = H_SYNC_START,
    parameter int H_SYNC_END_CFG   = H_SYNC_END,
    parameter int H_TOTAL_CFG      = H_TOTAL,
    parameter int V_ACTIVE_CFG     = V_ACTIVE,
    parameter int V_SYNC_START_CFG = V_SYNC_START,
    parameter int V_SYNC_END_CFG   = V_SYNC_END,
    parameter int V_TOTAL_CFG      = V_TOTAL
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pix_en,
    input  logic [MAZE_W*MAZE_H-1:0] maze_data,
    input  logic                     maze_finish,
    input  logic [3:0]               cursor_x,
    input  logic [3:0]               cursor_y,
    output logic                     hsync,
    output logic                     vsync,
    output logic                     video_on,
    output logic [7:0]               rgb,
    output logic                     frame_start,
    output logic                     snapshot_valid
);

    localparam int CELL_SH  = $clog2(CELL_PX);
    localparam int IDX_W    = $clog2(MAZE_W * MAZE_H);
    localparam int WIN_X_LO_I = ORIGIN_X;
    localparam int WIN_X_HI_I = ORIGIN_X + MAZE_W * CELL_PX;
    localparam int WIN_Y_LO_I = ORIGIN_Y;
    localparam int WIN_Y_HI_I = ORIGIN_Y + MAZE_H * CELL_PX;
    localparam int CELL_MASK_I = CELL_PX - 1;
    // One extra bit so a window ending exactly at 2**CNT_W still compares right.
    localparam logic [CNT_W:0]   WIN_X_LO  = WIN_X_LO_I[CNT_W:0];
    localparam logic [CNT_W:0]   WIN_X_HI  = WIN_X_HI_I[CNT_W:0];
    localparam logic [CNT_W:0]   WIN_Y_LO  = WIN_Y_LO_I[CNT_W:0];
    localparam logic [CNT_W:0]   WIN_Y_HI  = WIN_Y_HI_I[CNT_W:0];
    localparam logic [CNT_W-1:0] CELL_MASK = CELL_MASK_I[CNT_W-1:0];

    logic [CNT_W-1:0]         h_cnt_s;
    logic [CNT_W-1:0]         v_cnt_s;
    vga_decode_t              decode_s;

    logic [MAZE_W*MAZE_H-1:0] maze_snap_r;
    logic [3:0]               cur_x_r;
    logic [3:0]               cur_y_r;
    logic                     snap_valid_r;

    logic                     in_win_s;
    logic [CNT_W-1:0]         dx_s;
    logic [CNT_W-1:0]         dy_s;
    logic [CNT_W-1:0]         cx_s;
    logic [CNT_W-1:0]         cy_s;
    logic [IDX_W-1:0]         cell_idx_s;
    logic                     cursor_hit_s;
    logic                     path_bit_s;
`ifdef MAZE_GRID_LINES_EN
    logic                     grid_hit_s;
`endif
    logic [7:0]               pix_colour_s;

    logic                     hsync_r;
    logic                     vsync_r;
    logic                     video_on_r;
    logic [7:0]               rgb_r;
    logic                     frame_start_r;

    vga_timing_gen #(
        .H_ACTIVE_CFG     (H_ACTIVE_CFG),
        .H_SYNC_START_CFG (H_SYNC_START_CFG),
        .H_SYNC_END_CFG   (H_SYNC_END_CFG),
        .H_TOTAL_CFG      (H_TOTAL_CFG),
        .V_ACTIVE_CFG     (V_ACTIVE_CFG),
        .V_SYNC_START_CFG (V_SYNC_START_CFG),
        .V_SYNC_END_CFG   (V_SYNC_END_CFG),
        .V_TOTAL_CFG      (V_TOTAL_CFG)
    ) u_timing (
        .clk    (clk),
        .reset  (reset),
        .pix_en (pix_en),
        .h_cnt  (h_cnt_s),
        .v_cnt  (v_cnt_s),
        .decode (decode_s)
    );

    // Once-per-frame snapshot of maze, cursor and finish flag at vblank start.
    always_ff @(posedge clk) begin
        if (reset) begin
            maze_snap_r  <= {(MAZE_W*MAZE_H){CELL_WALL}};
            cur_x_r      <= 4'd0;
            cur_y_r      <= 4'd0;
            snap_valid_r <= 1'b0;
        end else if (pix_en && decode_s.snap) begin
            maze_snap_r  <= maze_data;
            cur_x_r      <= cursor_x;
            cur_y_r      <= cursor_y;
            snap_valid_r <= maze_finish;
        end
    end

    // Window membership and cell coordinates. The subtraction may wrap when
    // outside the window, but its result is only consumed when in_win_s is set.
    always_comb begin
        in_win_s     = ({1'b0, h_cnt_s} >= WIN_X_LO) && ({1'b0, h_cnt_s} < WIN_X_HI) &&
                       ({1'b0, v_cnt_s} >= WIN_Y_LO) && ({1'b0, v_cnt_s} < WIN_Y_HI);
        dx_s         = h_cnt_s - WIN_X_LO[CNT_W-1:0];
        dy_s         = v_cnt_s - WIN_Y_LO[CNT_W-1:0];
        cx_s         = dx_s >> CELL_SH;
        cy_s         = dy_s >> CELL_SH;
        cell_idx_s   = IDX_W'(int'(cy_s) * MAZE_W + int'(cx_s));
        // Cursor values beyond the maze never equal an in-window cell.
        cursor_hit_s = (cx_s == {{(CNT_W-4){1'b0}}, cur_x_r}) &&
                       (cy_s == {{(CNT_W-4){1'b0}}, cur_y_r});
        path_bit_s   = maze_snap_r[cell_idx_s];
    end

`ifdef MAZE_GRID_LINES_EN
    // Grid line on the first pixel column/row of every cell.
    always_comb begin
        grid_hit_s = ((dx_s & CELL_MASK) == {CNT_W{1'b0}}) ||
                     ((dy_s & CELL_MASK) == {CNT_W{1'b0}});
    end
`endif

    // Pixel colour in priority order: blanking, border, cursor, grid, cell.
    always_comb begin
        pix_colour_s = COL_BLANK;
        if (!decode_s.active) begin
            pix_colour_s = COL_BLANK;
        end else if (!in_win_s) begin
            pix_colour_s = COL_BORDER;
        end else if (cursor_hit_s) begin
            pix_colour_s = COL_CURSOR;
`ifdef MAZE_GRID_LINES_EN
        end else if (grid_hit_s) begin
            pix_colour_s = COL_GRID;
`endif
        end else if (path_bit_s == CELL_PATH) begin
            pix_colour_s = COL_PATH;
        end else begin
            pix_colour_s = COL_WALL;
        end
    end

    // Output registers: describe the position held before each pix_en edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_r       <= 1'b1;
            vsync_r       <= 1'b1;
            video_on_r    <= 1'b0;
            rgb_r         <= COL_BLANK;
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= pix_en & decode_s.frame_start;
            if (pix_en) begin
                hsync_r    <= decode_s.hsync;
                vsync_r    <= decode_s.vsync;
                video_on_r <= decode_s.active;
                rgb_r      <= pix_colour_s;
            end
        end
    end

    assign hsync          = hsync_r;
    assign vsync          = vsync_r;
    assign video_on       = video_on_r;
    assign rgb            = rgb_r;
    assign frame_start    = frame_start_r;
    assign snapshot_valid = snap_valid_r;

endmodule

// File: tb/tb_maze_vga_renderer.sv
// Bench for maze_vga_renderer. Two instances share stimulus: a reduced-raster
// 8x8 maze (small timing, 2 px cells, so whole frames run quickly) and the
// default 640x480 configuration (line timing and reset behaviour). A
// position/arithmetic reference model predicts every output on every clock;
// pixel tables and hand sequences cover snapshot isolation, out-of-range
// cursor, mid-frame reset and frame period.
module tb_maze_vga_renderer;

    typedef struct {
        int ha, hss, hse, ht, va, vss, vse, vt, mw, mh, cpx, ox, oy;
    } geom_t;

    typedef struct {
        int         h;
        int         v;
        logic       vo;
        logic [7:0] rgb;
    } pix_vec_t;

    localparam int SHT = 52;
    localparam int SVT = 36;
    localparam int SF  = SHT * SVT;

    logic         clk = 1'b0;
    logic         reset;
    logic         pix_en;
    logic [63:0]  maze_s;
    logic [255:0] maze_d;
    logic         maze_finish;
    logic [3:0]   cursor_x;
    logic [3:0]   cursor_y;

    logic s_hsync, s_vsync, s_video_on, s_frame_start, s_snapshot_valid;
    logic d_hsync, d_vsync, d_video_on, d_frame_start, d_snapshot_valid;
    logic [7:0] s_rgb, d_rgb;

    always #5 clk = ~clk;

    maze_vga_renderer #(
        .MAZE_W(8), .MAZE_H(8), .CELL_PX(2), .ORIGIN_X(4), .ORIGIN_Y(4),
        .H_ACTIVE_CFG(40), .H_SYNC_START_CFG(44), .H_SYNC_END_CFG(47), .H_TOTAL_CFG(SHT),
        .V_ACTIVE_CFG(30), .V_SYNC_START_CFG(33), .V_SYNC_END_CFG(34), .V_TOTAL_CFG(SVT)
    ) dut_s (
        .clk(clk), .reset(reset), .pix_en(pix_en), .maze_data(maze_s),
        .maze_finish(maze_finish), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .hsync(s_hsync), .vsync(s_vsync), .video_on(s_video_on), .rgb(s_rgb),
        .frame_start(s_frame_start), .snapshot_valid(s_snapshot_valid)
    );

    maze_vga_renderer dut_d (
        .clk(clk), .reset(reset), .pix_en(pix_en), .maze_data(maze_d),
        .maze_finish(maze_finish), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .hsync(d_hsync), .vsync(d_vsync), .video_on(d_video_on), .rgb(d_rgb),
        .frame_start(d_frame_start), .snapshot_valid(d_snapshot_valid)
    );

    geom_t gs, gd;
    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: t = pixel ticks since reset release.
    int           t;
    logic [255:0] snap_s_m, snap_d_m;
    int           cx_s_m, cy_s_m, cx_d_m, cy_d_m;
    logic         sv_s_m, sv_d_m;
    logic [12:0]  exp_s, exp_d;
    int           last_h, last_v;
    logic [8:0]   fb [0:SVT-1][0:SHT-1];

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (tick %0d, time %0t)", name, act, exp, t, $time);
        end
    endtask

    // {hsync, vsync, video_on, rgb} for raster tick tt, computed from the rules.
    function automatic logic [10:0] pix_model(geom_t g, int tt, logic [255:0] snap, int cxs, int cys);
        int h, v, cx, cy;
        logic hs, vs, vo;
        logic [7:0] c;
        h  = tt % g.ht;
        v  = (tt / g.ht) % g.vt;
        hs = !(h >= g.hss && h <= g.hse);
        vs = !(v >= g.vss && v <= g.vse);
        vo = (h < g.ha) && (v < g.va);
        if (!vo) c = 8'h00;
        else if (h < g.ox || h >= g.ox + g.mw * g.cpx || v < g.oy || v >= g.oy + g.mh * g.cpx) c = 8'h03;
        else begin
            cx = (h - g.ox) / g.cpx;
            cy = (v - g.oy) / g.cpx;
            if (cx == cxs && cy == cys) c = 8'hE0;
`ifdef MAZE_GRID_LINES_EN
            else if ((h - g.ox) % g.cpx == 0 || (v - g.oy) % g.cpx == 0) c = 8'h92;
`endif
            else if (snap[cx + g.mw * cy]) c = 8'hFF;
            else c = 8'h00;
        end
        return {hs, vs, vo, c};
    endfunction

    function automatic logic is_snap_point(geom_t g, int tt);
        return ((tt % g.ht) == 0) && (((tt / g.ht) % g.vt) == g.va);
    endfunction

    task automatic model_update(input logic pe, input logic rst);
        if (rst) begin
            t = 0;
            snap_s_m = '0; snap_d_m = '0;
            cx_s_m = 0; cy_s_m = 0; cx_d_m = 0; cy_d_m = 0;
            sv_s_m = 1'b0; sv_d_m = 1'b0;
            exp_s = {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
            exp_d = exp_s;
        end else begin
            exp_s[1] = 1'b0;
            exp_d[1] = 1'b0;
            if (pe) begin
                exp_s[12:2] = pix_model(gs, t, snap_s_m, cx_s_m, cy_s_m);
                exp_d[12:2] = pix_model(gd, t, snap_d_m, cx_d_m, cy_d_m);
                exp_s[1] = (t % (gs.ht * gs.vt)) == 0;
                exp_d[1] = (t % (gd.ht * gd.vt)) == 0;
                if (is_snap_point(gs, t)) begin
                    snap_s_m = {192'd0, maze_s};
                    cx_s_m = int'(cursor_x); cy_s_m = int'(cursor_y); sv_s_m = maze_finish;
                end
                if (is_snap_point(gd, t)) begin
                    snap_d_m = maze_d;
                    cx_d_m = int'(cursor_x); cy_d_m = int'(cursor_y); sv_d_m = maze_finish;
                end
                last_h = t % gs.ht;
                last_v = (t / gs.ht) % gs.vt;
                t++;
            end
            exp_s[0] = sv_s_m;
            exp_d[0] = sv_d_m;
        end
    endtask

    task automatic step(input logic pe, input logic rst);
        @(negedge clk);
        pix_en = pe;
        reset  = rst;
        @(posedge clk);
        #1;
        model_update(pe, rst);
        check_val("out_small", {19'd0, s_hsync, s_vsync, s_video_on, s_rgb, s_frame_start, s_snapshot_valid},
                  {19'd0, exp_s});
        check_val("out_default", {19'd0, d_hsync, d_vsync, d_video_on, d_rgb, d_frame_start, d_snapshot_valid},
                  {19'd0, exp_d});
        if (pe && !rst) fb[last_v][last_h] = {s_video_on, s_rgb};
    endtask

    task automatic run_ticks(input int n);
        int done;
        int clocks;
        logic pe;
        done = 0;
        clocks = 0;
        while (done < n && clocks < n * 16 + 64) begin
            pe = ($urandom_range(0, 2) != 0);
            step(pe, 1'b0);
            if (pe) done++;
            clocks++;
        end
        if (done < n) check_val("run_ticks_budget", done, n);
    endtask

    task automatic check_pix(input string name, input pix_vec_t pv);
        check_val(name, {23'd0, fb[pv.v][pv.h]}, {23'd0, pv.vo, pv.rgb});
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached at %0t", $time);
        $fatal(1, "time limit");
    end

    initial begin
        pix_vec_t tab1[8];
        pix_vec_t tab2[6];
        int e0_count;
        int k, fs1, fs2, hs_fall, hs_low, clocks, target;
        logic pe;

        gs = '{40, 44, 47, SHT, 30, 33, 34, SVT, 8, 8, 2, 4, 4};
        gd = '{640, 656, 751, 800, 480, 490, 491, 525, 16, 16, 16, 192, 112};

        // Frame after first snapshot: only cell 0 is path, cursor (7,7).
        tab1[0] = '{5, 5, 1'b1, 8'hFF};
        tab1[1] = '{7, 15, 1'b1, 8'h00};
        tab1[2] = '{18, 18, 1'b1, 8'hE0};
        tab1[3] = '{2, 2, 1'b1, 8'h03};
        tab1[4] = '{20, 5, 1'b1, 8'h03};
        tab1[5] = '{45, 2, 1'b0, 8'h00};
`ifdef MAZE_GRID_LINES_EN
        tab1[6] = '{4, 4, 1'b1, 8'h92};
        tab1[7] = '{6, 4, 1'b1, 8'h92};
`else
        tab1[6] = '{4, 4, 1'b1, 8'hFF};
        tab1[7] = '{6, 4, 1'b1, 8'h00};
`endif
        // Frame after the all-path snapshot, cursor still (7,7).
        tab2[0] = '{7, 5, 1'b1, 8'hFF};
        tab2[1] = '{7, 15, 1'b1, 8'hFF};
        tab2[2] = '{18, 18, 1'b1, 8'hE0};
        tab2[3] = '{19, 19, 1'b1, 8'hE0};
        tab2[4] = '{5, 20, 1'b1, 8'h03};
`ifdef MAZE_GRID_LINES_EN
        tab2[5] = '{6, 4, 1'b1, 8'h92};
`else
        tab2[5] = '{6, 4, 1'b1, 8'hFF};
`endif

        reset = 1'b1; pix_en = 1'b0;
        maze_s = 64'h1; maze_d = 256'h1; maze_finish = 1'b0;
        cursor_x = 4'd7; cursor_y = 4'd7;
        t = 0;

        for (int i = 0; i < 4; i++) step(1'($urandom_range(0, 1)), 1'b1);

        // Frame 0 ends with the first snapshot (finish flag low).
        run_ticks(SF);
        check_val("snapshot_valid_f0", {31'd0, s_snapshot_valid}, 32'd0);

        // Frame 1: inputs change at line 11 must not show in this frame.
        run_ticks(11 * SHT);
        maze_s = '1; maze_d = '1; maze_finish = 1'b1;
        run_ticks(SF - 11 * SHT);
        foreach (tab1[i]) check_pix($sformatf("frame1_pix_%0d", i), tab1[i]);
        check_val("snapshot_valid_f1", {31'd0, s_snapshot_valid}, 32'd1);

        // Frame 2: new maze visible; out-of-range cursor latched at its end.
        cursor_x = 4'd15; cursor_y = 4'd15;
        run_ticks(SF);
        foreach (tab2[i]) check_pix($sformatf("frame2_pix_%0d", i), tab2[i]);

        // Frame 3: cursor (15,15) lies outside the 8x8 maze, nothing is cursor red.
        run_ticks(SF);
        e0_count = 0;
        for (int v = 0; v < 30; v++)
            for (int h = 0; h < 40; h++)
                if (fb[v][h][7:0] == 8'hE0) e0_count++;
        check_val("no_cursor_out_of_range", e0_count, 0);
`ifdef MAZE_GRID_LINES_EN
        check_pix("frame3_grid", '{18, 18, 1'b1, 8'h92});
`else
        check_pix("frame3_path", '{18, 18, 1'b1, 8'hFF});
`endif
        check_pix("frame3_path_odd", '{19, 19, 1'b1, 8'hFF});

        // Random input changes at random times, checked cycle by cycle.
        for (int i = 0; i < 30; i++) begin
            run_ticks($urandom_range(50, 200));
            maze_s = {$urandom, $urandom};
            for (int w = 0; w < 8; w++) maze_d[w*32 +: 32] = $urandom;
            cursor_x = 4'($urandom_range(0, 15));
            cursor_y = 4'($urandom_range(0, 15));
            maze_finish = 1'($urandom_range(0, 1));
        end

        // Reset in mid-frame at (30,20), then measure restart timing.
        target = 20 * SHT + 30;
        run_ticks((target - (t % SF) + SF) % SF);
        for (int i = 0; i < 6; i++) step(1'($urandom_range(0, 1)), 1'b1);
        k = 0; fs1 = -1; fs2 = -1; hs_fall = -1; hs_low = 0; clocks = 0;
        while (fs2 < 0 && clocks < 20000) begin
            pe = ($urandom_range(0, 2) != 0);
            step(pe, 1'b0);
            clocks++;
            if (pe) begin
                k++;
                if (s_frame_start) begin
                    if (fs1 < 0) fs1 = k;
                    else fs2 = k;
                end
                if (!d_hsync && k <= 800) begin
                    hs_low++;
                    if (hs_fall < 0) hs_fall = k;
                end
            end
        end
        check_val("first_frame_start_tick", fs1, 1);
        check_val("frame_period_ticks", fs2 - fs1, SF);
        check_val("hsync_first_low_tick", hs_fall, 657);
        check_val("hsync_low_width", hs_low, 96);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
